// File: rtl/pci_bus_pkg.sv
// Shared PCI bus definitions: bus-master state encoding, data width and
// the per-word address step. Used by the requester and the central arbiter.
package pci_bus_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] ADDR_INC = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ_WAIT = 3'd1,
    ST_ADDR     = 3'd2,
    ST_DATA     = 3'd3,
    ST_TURN     = 3'd4
  } bus_state_e;

  // Address of the following 32-bit word, wrapping modulo 2^32
  function automatic logic [DATA_W-1:0] next_word_addr(input logic [DATA_W-1:0] addr);
    return addr + ADDR_INC;
  endfunction

endpackage

// File: rtl/pci_lat_timer.sv
// Latency timer: loadable down-counter that sticks at zero and flags it.
module pci_lat_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Load wins over decrement; decrementing stops at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/pci_master_req_ctrl.sv
// PCI initiator bus-ownership controller: requests the bus for a local burst
// write, runs address/data phases, yields on latency-timer expiry and
// re-requests to finish preempted bursts.
module pci_master_req_ctrl
  import pci_bus_pkg::*;
#(
  parameter int LEN_W     = 8,
  parameter int LAT_TIMER = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              xfer_req,
  input  logic [31:0]       xfer_addr,
  input  logic [LEN_W-1:0]  xfer_len,
  output logic              xfer_busy,
  output logic              xfer_done,
  input  logic [31:0]       wr_data,
  output logic              wr_data_ack,
  output logic              REQ,
  input  logic              GNT,
  input  logic              FRAME_in,
  input  logic              IRDY_in,
  input  logic              TRDY,
  output logic              FRAME_out,
  output logic              IRDY_out,
  output logic              ctl_oe,
  output logic [31:0]       AD_out
);

  localparam int LAT_W = (LAT_TIMER < 2) ? 1 : $clog2(LAT_TIMER + 1);

  bus_state_e        state_r;
  bus_state_e        state_nxt_s;
  logic [DATA_W-1:0] cur_addr_r;
  logic [LEN_W-1:0]  rem_r;
  logic              req_r;
  logic              busy_r;
  logic              done_r;
  logic              last_s;
  logic              lat_zero_s;
  logic              lat_load_s;
  logic              lat_dec_s;

  // The timer is loaded as the address phase begins and runs through it, so
  // LAT_TIMER data phases are guaranteed before a withdrawn GNT ends the burst.
  assign lat_load_s = (state_r == ST_REQ_WAIT) && (state_nxt_s == ST_ADDR);
  assign lat_dec_s  = (state_r == ST_ADDR) || (state_r == ST_DATA);

  pci_lat_timer #(
    .W (LAT_W)
  ) u_lat_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (lat_load_s),
    .load_val (LAT_W'(LAT_TIMER)),
    .dec      (lat_dec_s),
    .zero     (lat_zero_s)
  );

  // Final data phase: burst exhausted, or timer expired with grant withdrawn
  assign last_s = (rem_r == LEN_W'(1)) | (lat_zero_s & ~GNT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (xfer_req && (xfer_len != {LEN_W{1'b0}})) begin
          state_nxt_s = ST_REQ_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ_WAIT: begin
        if (GNT && !FRAME_in && !IRDY_in) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_REQ_WAIT;
        end
      end
      ST_ADDR: begin
        state_nxt_s = ST_DATA;
      end
      ST_DATA: begin
        if (TRDY && last_s) begin
          state_nxt_s = ST_TURN;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_TURN: begin
        if (rem_r == {LEN_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Bus-side outputs decoded from the current state
  always_comb begin
    ctl_oe      = 1'b0;
    FRAME_out   = 1'b0;
    IRDY_out    = 1'b0;
    AD_out      = 32'd0;
    wr_data_ack = 1'b0;
    case (state_r)
      ST_ADDR: begin
        ctl_oe    = 1'b1;
        FRAME_out = 1'b1;
        AD_out    = cur_addr_r;
      end
      ST_DATA: begin
        ctl_oe      = 1'b1;
        IRDY_out    = 1'b1;
        FRAME_out   = ~last_s;
        AD_out      = wr_data;
        wr_data_ack = TRDY;
      end
      ST_TURN: begin
        ctl_oe = 1'b1;
      end
      default: begin
        ctl_oe = 1'b0;
      end
    endcase
  end

  // Command latch, word/address bookkeeping, REQ and completion handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_r <= 32'd0;
      rem_r      <= {LEN_W{1'b0}};
      req_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (xfer_req) begin
            if (xfer_len != {LEN_W{1'b0}}) begin
              cur_addr_r <= xfer_addr;
              rem_r      <= xfer_len;
              req_r      <= 1'b1;
              busy_r     <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (TRDY) begin
            rem_r      <= rem_r - LEN_W'(1);
            cur_addr_r <= next_word_addr(cur_addr_r);
            if (rem_r == LEN_W'(1)) begin
              req_r <= 1'b0;
            end
          end
        end
        ST_TURN: begin
          if (rem_r == {LEN_W{1'b0}}) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign REQ       = req_r;
  assign xfer_busy = busy_r;
  assign xfer_done = done_r;

endmodule
